cordic_fetch_queue: RTL and testbench



---
 rtl/cordic_pkg.sv | 60 ++++++
 rtl/cordic_fetch_fifo.sv | 53 +++++
 rtl/cordic_fetch_queue.sv | 200 ++++++++++++++++++++
 tb/tb_cordic_fetch_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the HCORDIC fetch/decode stage: opcode encoding,
// mode/operation constants, packet field offsets and micro-op control bits.
package cordic_pkg;

   // Instruction opcodes; 7 and 8 are reserved and decode as illegal
   typedef enum logic [3:0] {
      OP_SIN_COS    = 4'd0,
      OP_SINH_COSH  = 4'd1,
      OP_ARCTAN     = 4'd2,
      OP_ARCTANH    = 4'd3,
      OP_EXP        = 4'd4,
      OP_SQR_ROOT   = 4'd5,
      OP_DIVISION   = 4'd6,
      OP_RSVD7      = 4'd7,
      OP_RSVD8      = 4'd8,
      OP_NAT_LOG    = 4'd9,
      OP_HYPOTENUSE = 4'd10
   } cordic_op_e;

   localparam logic [1:0] MODE_LINEAR     = 2'b00;
   localparam logic [1:0] MODE_CIRCULAR   = 2'b01;
   localparam logic [1:0] MODE_HYPERBOLIC = 2'b11;

   localparam logic OPER_VECTORING = 1'b0;
   localparam logic OPER_ROTATION  = 1'b1;

   // Packet layout, LSB first: x, y, z, opcode[4], tag
   function automatic int data_w(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int y_lsb(input int exp_w, input int man_w);
      return data_w(exp_w, man_w);
   endfunction

   function automatic int z_lsb(input int exp_w, input int man_w);
      return 2 * data_w(exp_w, man_w);
   endfunction

   function automatic int opc_lsb(input int exp_w, input int man_w);
      return 3 * data_w(exp_w, man_w);
   endfunction

   function automatic int tag_lsb(input int exp_w, input int man_w);
      return 3 * data_w(exp_w, man_w) + 4;
   endfunction

   function automatic int pkt_w(input int exp_w, input int man_w, input int tag_w);
      return tag_lsb(exp_w, man_w) + tag_w;
   endfunction

   // Control half of a micro-op; the top concatenates the width-parameterised
   // x/y/z seeds and tag around it
   typedef struct packed {
      logic [1:0] mode;
      logic       operation;
      logic       natlog;
   } uop_ctrl_t;

endpackage

// File: rtl/cordic_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of packed micro-ops. Pointers wrap modulo
// DEPTH; the occupancy counter is one bit wider to tell full from empty.
module cordic_fetch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [W-1:0]     data_i,
   input  logic             pop_i,
   output logic [W-1:0]     data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_q];

   // Overflow/underflow requests are ignored rather than corrupting state
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Storage needs no reset; the counter alone defines what is valid
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   // Pointer and occupancy update; simultaneous push/pop leaves count unchanged
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PTR_W'(1);
         if (do_pop)  rd_q <= rd_q + PTR_W'(1);
         if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
         else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/cordic_fetch_queue.sv
// HCORDIC fetch/decode stage: arbitrates raw and pre-processed packets
// (pre-processed wins), decodes to a CORDIC micro-op, queues it and issues
// one op per cycle under stall. Define CORDIC_FETCH_BYPASS_EN to let a
// legal packet skip an empty queue and reach the outputs one edge earlier.
module cordic_fetch_queue
   import cordic_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 8,
   parameter int DEPTH = 4,
   localparam int DATA_W = 1 + EXP_W + MAN_W,
   localparam int PKT_W  = pkt_w(EXP_W, MAN_W, TAG_W),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              raw_valid_i,
   output logic              raw_ready_o,
   input  logic [PKT_W-1:0]  raw_packet_i,
   input  logic              proc_valid_i,
   output logic              proc_ready_o,
   input  logic [PKT_W-1:0]  proc_packet_i,
   input  logic              stall_i,
   output logic [DATA_W-1:0] x_input_o,
   output logic [DATA_W-1:0] y_input_o,
   output logic [DATA_W-1:0] z_input_o,
   output logic [1:0]        mode_o,
   output logic              operation_o,
   output logic [TAG_W-1:0]  tag_out_o,
   output logic              load_o,
   output logic              natlog_flag_o,
   output logic              illegal_op_o,
   output logic [CNT_W-1:0]  queue_count_o
);

   localparam int Y_LSB   = y_lsb(EXP_W, MAN_W);
   localparam int Z_LSB   = z_lsb(EXP_W, MAN_W);
   localparam int OPC_LSB = opc_lsb(EXP_W, MAN_W);
   localparam int TAG_LSB = tag_lsb(EXP_W, MAN_W);
   localparam int UOP_W   = 3 * DATA_W + TAG_W + $bits(uop_ctrl_t);

   localparam logic [DATA_W-1:0] ONE =
      {1'b0, 1'b0, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};

   // ---------------- arbitration ----------------
   logic full, empty;
   logic proc_acc, raw_acc, acc;
   logic [PKT_W-1:0] sel_pkt;

   assign proc_ready_o = ~full;
   assign raw_ready_o  = ~full & ~proc_valid_i;
   assign proc_acc     = proc_valid_i & proc_ready_o;
   assign raw_acc      = raw_valid_i & raw_ready_o;
   assign acc          = proc_acc | raw_acc;
   assign sel_pkt      = proc_acc ? proc_packet_i : raw_packet_i;

   // ---------------- decode ----------------
   cordic_op_e        opc;
   logic [DATA_W-1:0] px, py, pz;
   logic [TAG_W-1:0]  ptag;
   logic [EXP_W-1:0]  xe, ye, xe_m1, ye_m1;

   assign px   = sel_pkt[0 +: DATA_W];
   assign py   = sel_pkt[Y_LSB +: DATA_W];
   assign pz   = sel_pkt[Z_LSB +: DATA_W];
   assign opc  = cordic_op_e'(sel_pkt[OPC_LSB +: 4]);
   assign ptag = sel_pkt[TAG_LSB +: TAG_W];

   // Exponent halving for sqr_root saturates at zero instead of wrapping
   assign xe    = px[DATA_W-2 -: EXP_W];
   assign ye    = py[DATA_W-2 -: EXP_W];
   assign xe_m1 = (xe == '0) ? '0 : xe - EXP_W'(1);
   assign ye_m1 = (ye == '0) ? '0 : ye - EXP_W'(1);

   logic [DATA_W-1:0] dx, dy, dz;
   uop_ctrl_t         dctrl;
   logic              legal;

   // Source-specific opcode decode; anything not listed is illegal
   always_comb begin
      dx    = '0;
      dy    = '0;
      dz    = '0;
      dctrl = '0;
      legal = 1'b0;
      if (proc_acc) begin
         case (opc)
            OP_SQR_ROOT: begin
               legal = 1'b1;
               dx    = {px[DATA_W-1], xe_m1, px[MAN_W-1:0]};
               dy    = {1'b0, ye_m1, py[MAN_W-1:0]};
               dctrl = '{mode: MODE_HYPERBOLIC, operation: OPER_VECTORING, natlog: 1'b0};
            end
            OP_NAT_LOG: begin
               legal = 1'b1;
               dx    = px;
               dy    = {1'b0, py[DATA_W-2:0]};
               dctrl = '{mode: MODE_HYPERBOLIC, operation: OPER_VECTORING, natlog: 1'b1};
            end
            default: ;
         endcase
      end else begin
         case (opc)
            OP_SIN_COS: begin
               legal = 1'b1; dx = ONE; dz = pz;
               dctrl = '{mode: MODE_CIRCULAR, operation: OPER_ROTATION, natlog: 1'b0};
            end
            OP_SINH_COSH: begin
               legal = 1'b1; dx = ONE; dz = pz;
               dctrl = '{mode: MODE_HYPERBOLIC, operation: OPER_ROTATION, natlog: 1'b0};
            end
            OP_ARCTAN: begin
               legal = 1'b1; dx = ONE; dy = py;
               dctrl = '{mode: MODE_CIRCULAR, operation: OPER_VECTORING, natlog: 1'b0};
            end
            OP_ARCTANH: begin
               legal = 1'b1; dx = ONE; dy = py;
               dctrl = '{mode: MODE_HYPERBOLIC, operation: OPER_VECTORING, natlog: 1'b0};
            end
            OP_EXP: begin
               legal = 1'b1; dx = ONE; dy = ONE; dz = pz;
               dctrl = '{mode: MODE_HYPERBOLIC, operation: OPER_ROTATION, natlog: 1'b0};
            end
            OP_DIVISION: begin
               legal = 1'b1; dx = px; dy = py;
               dctrl = '{mode: MODE_LINEAR, operation: OPER_VECTORING, natlog: 1'b0};
            end
            OP_HYPOTENUSE: begin
               legal = 1'b1; dx = px; dy = py;
               dctrl = '{mode: MODE_CIRCULAR, operation: OPER_VECTORING, natlog: 1'b0};
            end
            default: ;
         endcase
      end
   end

   // ---------------- queue ----------------
   logic             issue_q_pop, bypass, push;
   logic [UOP_W-1:0] dec_uop, head_uop, iss_uop;

   assign dec_uop     = {dx, dy, dz, ptag, dctrl};
   assign issue_q_pop = ~empty & ~stall_i;

`ifdef CORDIC_FETCH_BYPASS_EN
   assign bypass = empty & ~stall_i & acc & legal;
`else
   assign bypass = 1'b0;
`endif

   assign push    = acc & legal & ~bypass;
   assign iss_uop = issue_q_pop ? head_uop : dec_uop;

   cordic_fetch_fifo #(.W(UOP_W), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push),
      .data_i  (dec_uop),
      .pop_i   (issue_q_pop),
      .data_o  (head_uop),
      .full_o  (full),
      .empty_o (empty),
      .count_o (queue_count_o)
   );

   // ---------------- issue registers ----------------
   logic [DATA_W-1:0] iss_x, iss_y, iss_z;
   logic [TAG_W-1:0]  iss_tag;
   uop_ctrl_t         iss_ctrl;

   assign {iss_x, iss_y, iss_z, iss_tag, iss_ctrl} = iss_uop;

   // Output registers hold the last issued op; load/illegal are single pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         x_input_o     <= '0;
         y_input_o     <= '0;
         z_input_o     <= '0;
         mode_o        <= '0;
         operation_o   <= 1'b0;
         tag_out_o     <= '0;
         natlog_flag_o <= 1'b0;
         load_o        <= 1'b0;
         illegal_op_o  <= 1'b0;
      end else begin
         load_o       <= issue_q_pop | bypass;
         illegal_op_o <= acc & ~legal;
         if (issue_q_pop || bypass) begin
            x_input_o     <= iss_x;
            y_input_o     <= iss_y;
            z_input_o     <= iss_z;
            mode_o        <= iss_ctrl.mode;
            operation_o   <= iss_ctrl.operation;
            tag_out_o     <= iss_tag;
            natlog_flag_o <= iss_ctrl.natlog;
         end
      end
   end

endmodule

// File: tb/tb_cordic_fetch_queue.sv
// Directed bench for cordic_fetch_queue (default build, queue latency 2 edges).
module tb_cordic_fetch_queue;

   localparam int PKT_W = 8 + 4 + 96;
   localparam logic [31:0] ONE = 32'h3F800000;

   logic              clock = 1'b0;
   logic              reset;
   logic              raw_valid, proc_valid, stall;
   logic              raw_ready, proc_ready;
   logic [PKT_W-1:0]  raw_packet, proc_packet;
   logic [31:0]       x_o, y_o, z_o;
   logic [1:0]        mode_o;
   logic              oper_o, load_o, nat_o, ill_o;
   logic [7:0]        tag_o;
   logic [2:0]        cnt_o;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   cordic_fetch_queue dut (
      .clock         (clock),
      .reset         (reset),
      .raw_valid_i   (raw_valid),
      .raw_ready_o   (raw_ready),
      .raw_packet_i  (raw_packet),
      .proc_valid_i  (proc_valid),
      .proc_ready_o  (proc_ready),
      .proc_packet_i (proc_packet),
      .stall_i       (stall),
      .x_input_o     (x_o),
      .y_input_o     (y_o),
      .z_input_o     (z_o),
      .mode_o        (mode_o),
      .operation_o   (oper_o),
      .tag_out_o     (tag_o),
      .load_o        (load_o),
      .natlog_flag_o (nat_o),
      .illegal_op_o  (ill_o),
      .queue_count_o (cnt_o)
   );

   typedef struct {
      logic        src;     // 0 raw, 1 proc
      logic [3:0]  opc;
      logic [31:0] x, y, z;
      logic [7:0]  tag;
      logic        ill;
      logic [31:0] ex, ey, ez;
      logic [1:0]  em;
      logic        eo, en;
   } vec_t;

   function automatic logic [PKT_W-1:0] mk(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [31:0] z,
                                           input logic [7:0] tag);
      return {tag, op, z, y, x};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string pfx);
      chk({pfx, " x"}, x_o, 32'h0);
      chk({pfx, " y"}, y_o, 32'h0);
      chk({pfx, " z"}, z_o, 32'h0);
      chk({pfx, " mode"}, 32'(mode_o), 32'h0);
      chk({pfx, " oper"}, 32'(oper_o), 32'h0);
      chk({pfx, " tag"}, 32'(tag_o), 32'h0);
      chk({pfx, " load"}, 32'(load_o), 32'h0);
      chk({pfx, " natlog"}, 32'(nat_o), 32'h0);
      chk({pfx, " illegal"}, 32'(ill_o), 32'h0);
      chk({pfx, " count"}, 32'(cnt_o), 32'h0);
   endtask

   vec_t vt [13];

   initial begin
      // src opc x y z tag ill | ex ey ez mode oper nat
      vt[0]  = '{0, 0, 32'h11111111, 32'h22222222, 32'h3F000000, 8'h15, 0, ONE, 32'h0, 32'h3F000000, 2'b01, 1, 0};
      vt[1]  = '{0, 1, 32'h11111111, 32'h22222222, 32'h40000000, 8'h21, 0, ONE, 32'h0, 32'h40000000, 2'b11, 1, 0};
      vt[2]  = '{0, 2, 32'h12345678, 32'h3F800000, 32'h0BADBEEF, 8'h22, 0, ONE, 32'h3F800000, 32'h0, 2'b01, 0, 0};
      vt[3]  = '{0, 3, 32'h12345678, 32'h3E800000, 32'h0BADBEEF, 8'h23, 0, ONE, 32'h3E800000, 32'h0, 2'b11, 0, 0};
      vt[4]  = '{0, 4, 32'h12345678, 32'h55555555, 32'h3F000000, 8'h24, 0, ONE, ONE, 32'h3F000000, 2'b11, 1, 0};
      vt[5]  = '{0, 6, 32'h40000000, 32'h40400000, 32'h0BADBEEF, 8'h26, 0, 32'h40000000, 32'h40400000, 32'h0, 2'b00, 0, 0};
      vt[6]  = '{0, 10, 32'h40400000, 32'h40800000, 32'h0BADBEEF, 8'h2A, 0, 32'h40400000, 32'h40800000, 32'h0, 2'b01, 0, 0};
      vt[7]  = '{1, 5, 32'h40400000, 32'hBF800000, 32'h0BADBEEF, 8'h35, 0, 32'h3FC00000, 32'h3F000000, 32'h0, 2'b11, 0, 0};
      vt[8]  = '{1, 5, 32'h00400000, 32'h80200000, 32'h0BADBEEF, 8'h36, 0, 32'h00400000, 32'h00200000, 32'h0, 2'b11, 0, 0};
      vt[9]  = '{1, 9, 32'h40000000, 32'hC0000000, 32'h0BADBEEF, 8'h39, 0, 32'h40000000, 32'h40000000, 32'h0, 2'b11, 0, 1};
      vt[10] = '{0, 7, 32'h1, 32'h2, 32'h3, 8'h47, 1, 0, 0, 0, 0, 0, 0};
      vt[11] = '{0, 5, 32'h1, 32'h2, 32'h3, 8'h45, 1, 0, 0, 0, 0, 0, 0};
      vt[12] = '{1, 0, 32'h1, 32'h2, 32'h3, 8'h50, 1, 0, 0, 0, 0, 0, 0};

      reset = 1'b1; raw_valid = 0; proc_valid = 0; stall = 0;
      raw_packet = '0; proc_packet = '0;
      tick(); tick();
      chk_zero_outputs("reset");
      chk("reset proc_ready", 32'(proc_ready), 32'h1);
      reset = 1'b0;
      tick();

      // ---- table: one packet each, latency 2 edges ----
      for (int i = 0; i < 13; i++) begin
         if (vt[i].src) begin
            proc_packet = mk(vt[i].opc, vt[i].x, vt[i].y, vt[i].z, vt[i].tag);
            proc_valid  = 1'b1;
         end else begin
            raw_packet = mk(vt[i].opc, vt[i].x, vt[i].y, vt[i].z, vt[i].tag);
            raw_valid  = 1'b1;
         end
         tick();
         raw_valid = 0; proc_valid = 0;
         if (vt[i].ill) begin
            chk($sformatf("v%0d illegal pulse", i), 32'(ill_o), 32'h1);
            chk($sformatf("v%0d illegal count", i), 32'(cnt_o), 32'h0);
            chk($sformatf("v%0d illegal load", i), 32'(load_o), 32'h0);
            tick();
            chk($sformatf("v%0d illegal end", i), 32'(ill_o), 32'h0);
            chk($sformatf("v%0d illegal noload", i), 32'(load_o), 32'h0);
         end else begin
            chk($sformatf("v%0d queued", i), 32'(cnt_o), 32'h1);
            chk($sformatf("v%0d early load", i), 32'(load_o), 32'h0);
            tick();
            chk($sformatf("v%0d load", i), 32'(load_o), 32'h1);
            chk($sformatf("v%0d x", i), x_o, vt[i].ex);
            chk($sformatf("v%0d y", i), y_o, vt[i].ey);
            chk($sformatf("v%0d z", i), z_o, vt[i].ez);
            chk($sformatf("v%0d mode", i), 32'(mode_o), 32'(vt[i].em));
            chk($sformatf("v%0d oper", i), 32'(oper_o), 32'(vt[i].eo));
            chk($sformatf("v%0d tag", i), 32'(tag_o), 32'(vt[i].tag));
            chk($sformatf("v%0d natlog", i), 32'(nat_o), 32'(vt[i].en));
            chk($sformatf("v%0d drained", i), 32'(cnt_o), 32'h0);
         end
      end
      tick();
      chk("idle load", 32'(load_o), 32'h0);

      // ---- both sources valid: proc (nat_log) wins ----
      raw_packet  = mk(4'd0, 32'h0, 32'h0, 32'h3F000000, 8'hA1);
      proc_packet = mk(4'd9, 32'h40000000, 32'hC0000000, 32'h0, 8'hB2);
      raw_valid = 1; proc_valid = 1;
      #1;
      chk("arb raw_ready", 32'(raw_ready), 32'h0);
      chk("arb proc_ready", 32'(proc_ready), 32'h1);
      tick();
      proc_valid = 0;
      tick();
      raw_valid = 0;
      chk("arb first load", 32'(load_o), 32'h1);
      chk("arb first tag", 32'(tag_o), 32'hB2);
      chk("arb first natlog", 32'(nat_o), 32'h1);
      tick();
      chk("arb second load", 32'(load_o), 32'h1);
      chk("arb second tag", 32'(tag_o), 32'hA1);
      chk("arb second natlog", 32'(nat_o), 32'h0);
      chk("arb second x", x_o, ONE);
      tick();
      chk("arb idle", 32'(load_o), 32'h0);

      // ---- stall, fill to DEPTH, 5th waits, then back-to-back drain ----
      stall = 1;
      for (int i = 1; i <= 4; i++) begin
         raw_packet = mk(4'd0, 32'h0, 32'h0, 32'(i), 8'(i));
         raw_valid  = 1;
         tick();
         chk($sformatf("stall noload %0d", i), 32'(load_o), 32'h0);
      end
      raw_packet = mk(4'd0, 32'h0, 32'h0, 32'h5, 8'h5);
      chk("full count", 32'(cnt_o), 32'h4);
      chk("full raw_ready", 32'(raw_ready), 32'h0);
      chk("full proc_ready", 32'(proc_ready), 32'h0);
      tick();
      chk("full hold count", 32'(cnt_o), 32'h4);
      chk("full hold load", 32'(load_o), 32'h0);
      stall = 0;
      tick();
      chk("drain tag1", 32'(tag_o), 32'h1);
      chk("drain load1", 32'(load_o), 32'h1);
      tick();
      raw_valid = 0;
      for (int i = 2; i <= 5; i++) begin
         if (i > 2) tick();
         chk($sformatf("drain load%0d", i), 32'(load_o), 32'h1);
         chk($sformatf("drain tag%0d", i), 32'(tag_o), 32'(i));
         chk($sformatf("drain z%0d", i), z_o, 32'(i));
      end
      tick();
      chk("drain done load", 32'(load_o), 32'h0);
      chk("drain done count", 32'(cnt_o), 32'h0);

      // ---- reset with 3 entries queued ----
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         raw_packet = mk(4'd4, 32'h0, 32'h0, 32'h3F000000, 8'(8'h31 + i));
         raw_valid  = 1;
         tick();
      end
      raw_valid = 0;
      chk("pre-reset count", 32'(cnt_o), 32'h3);
      reset = 1;
      tick();
      reset = 0; stall = 0;
      chk_zero_outputs("midreset");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post-reset noload %0d", i), 32'(load_o), 32'h0);
         chk($sformatf("post-reset count %0d", i), 32'(cnt_o), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
